// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared states, register indices and screen limits for the VGA pixel writer
package vga_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        STROBE,
        HOLD,
        GAP
    } state_t;

    localparam logic [1:0] REG_X_LO = 2'd0;
    localparam logic [1:0] REG_X_HI = 2'd1;
    localparam logic [1:0] REG_Y    = 2'd2;
    localparam logic [1:0] REG_DATA = 2'd3;

    localparam int SCREEN_WIDTH  = 320;
    localparam int SCREEN_HEIGHT = 240;

    localparam logic [8:0] X_MAX = 9'(SCREEN_WIDTH - 1);
    localparam logic [7:0] Y_MAX = 8'(SCREEN_HEIGHT - 1);

    // Lowest-numbered register still pending; the colour register is always the last one.
    function automatic logic [1:0] first_pending(input logic [3:0] mask);
        if (mask[0]) return REG_X_LO;
        if (mask[1]) return REG_X_HI;
        if (mask[2]) return REG_Y;
        return REG_DATA;
    endfunction

endpackage

// File: rtl/vga_bus_strobe.sv
// rtl/vga_bus_strobe.sv - one register write on the MPU port: SETUP, STROBE, HOLD, GAP
// A start seen while idle or in the final cycle of a write chains the next write with no idle cycle.
module vga_bus_strobe
    import vga_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 1
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [2:0] reg_i,
    input  logic [7:0] data_i,
    output logic       cs_o,
    output logic       we_o,
    output logic [2:0] reg_o,
    output logic [7:0] data_o,
    output logic       hold_end_o,
    output logic       done_o
);

    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD    = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
    localparam logic       NO_GAP      = (GAP_CYCLES == 0);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       cs_q, we_q;
    logic [2:0] reg_q;
    logic [7:0] data_q;
    logic       finish, load;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        finish     = 1'b0;
        load       = 1'b0;
        hold_end_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SETUP;
                    load    = 1'b1;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = STROBE_LOAD;
            end
            STROBE: begin
                if (cnt_q == 4'd0) state_d = HOLD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            HOLD: begin
                hold_end_o = 1'b1;
                if (NO_GAP) begin
                    finish = 1'b1;
                end else begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt_q == 4'd0) finish = 1'b1;
                else               cnt_d  = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
        if (finish) begin
            if (start_i) begin
                state_d = SETUP;
                load    = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end
        done_o = finish;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            reg_q   <= 3'd0;
            data_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_q    <= (state_d == STROBE);
            we_q    <= (state_d == STROBE);
            if (load) begin
                reg_q  <= reg_i;
                data_q <= data_i;
            end
        end
    end

    assign cs_o   = cs_q;
    assign we_o   = we_q;
    assign reg_o  = reg_q;
    assign data_o = data_q;

endmodule

// File: rtl/vga_pixel_writer.sv
// rtl/vga_pixel_writer.sv - pixel command to VGA register-port writes with a shadow cache
// Registers whose cached value already matches the new command are skipped; colour always commits.
module vga_pixel_writer
    import vga_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmdValid,
    output logic       cmdReady,
    input  logic [8:0] cmdX,
    input  logic [7:0] cmdY,
    input  logic [7:0] cmdColor,
    output logic       mpuChipSelect,
    output logic       mpuWriteEnable,
    output logic [2:0] mpuRegisterSelect,
    output logic [7:0] mpuData,
    output logic       busy,
    output logic       rangeError
);

    // Only IDLE, LOAD and SETUP are used here; SETUP covers the whole bus sequence.
    state_t     ctl_q, ctl_d;
    logic [3:0] pend_q, pend_d;
    logic [1:0] cur_q, cur_d;
    logic       busy_q, busy_d;
    logic       rerr_q;
    logic [8:0] x_q;
    logic [7:0] y_q, color_q;
    logic [7:0] xlo_c_q, y_c_q;
    logic       xhi_c_q;
    logic       xlo_v_q, xhi_v_q, y_v_q;

    logic       accept, in_range, start;
    logic [1:0] sel;
    logic [3:0] miss;
    logic [7:0] bus_data;
    logic       bus_done, bus_hold_end;

    assign cmdReady = (ctl_q == IDLE) && !reset;
    assign accept   = cmdValid && cmdReady;
    assign in_range = (cmdX <= X_MAX) && (cmdY <= Y_MAX);

    assign miss = {1'b1,
                   !(y_v_q   && (y_c_q   == y_q)),
                   !(xhi_v_q && (xhi_c_q == x_q[8])),
                   !(xlo_v_q && (xlo_c_q == x_q[7:0]))};

    always_comb begin
        ctl_d  = ctl_q;
        pend_d = pend_q;
        cur_d  = cur_q;
        busy_d = busy_q;
        start  = 1'b0;
        sel    = first_pending(pend_q);
        case (ctl_q)
            IDLE: begin
                if (accept && in_range) begin
                    ctl_d  = LOAD;
                    busy_d = 1'b1;
                end
            end
            LOAD: begin
                sel    = first_pending(miss);
                start  = 1'b1;
                cur_d  = sel;
                pend_d = miss & ~(4'b0001 << sel);
                ctl_d  = SETUP;
            end
            SETUP: begin
                if (bus_done) begin
                    if (pend_q != 4'd0) begin
                        start  = 1'b1;
                        cur_d  = sel;
                        pend_d = pend_q & ~(4'b0001 << sel);
                    end else begin
                        ctl_d  = IDLE;
                        busy_d = 1'b0;
                    end
                end
            end
            default: ctl_d = IDLE;
        endcase
        case (sel)
            REG_X_LO: bus_data = x_q[7:0];
            REG_X_HI: bus_data = {7'd0, x_q[8]};
            REG_Y:    bus_data = y_q;
            default:  bus_data = color_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctl_q   <= IDLE;
            pend_q  <= 4'd0;
            cur_q   <= 2'd0;
            busy_q  <= 1'b0;
            rerr_q  <= 1'b0;
            x_q     <= 9'd0;
            y_q     <= 8'd0;
            color_q <= 8'd0;
            xlo_c_q <= 8'd0;
            xhi_c_q <= 1'b0;
            y_c_q   <= 8'd0;
            xlo_v_q <= 1'b0;
            xhi_v_q <= 1'b0;
            y_v_q   <= 1'b0;
        end else begin
            ctl_q  <= ctl_d;
            pend_q <= pend_d;
            cur_q  <= cur_d;
            busy_q <= busy_d;
            rerr_q <= accept && !in_range;
            if (accept) begin
                x_q     <= cmdX;
                y_q     <= cmdY;
                color_q <= cmdColor;
            end
            if (bus_hold_end) begin
                case (cur_q)
                    REG_X_LO: begin xlo_c_q <= x_q[7:0]; xlo_v_q <= 1'b1; end
                    REG_X_HI: begin xhi_c_q <= x_q[8];   xhi_v_q <= 1'b1; end
                    REG_Y:    begin y_c_q   <= y_q;      y_v_q   <= 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    assign busy       = busy_q;
    assign rangeError = rerr_q;

    vga_bus_strobe #(
        .STROBE_CYCLES(STROBE_CYCLES),
        .GAP_CYCLES   (GAP_CYCLES)
    ) u_bus (
        .clock_i   (clock),
        .reset_i   (reset),
        .start_i   (start),
        .reg_i     ({1'b0, sel}),
        .data_i    (bus_data),
        .cs_o      (mpuChipSelect),
        .we_o      (mpuWriteEnable),
        .reg_o     (mpuRegisterSelect),
        .data_o    (mpuData),
        .hold_end_o(bus_hold_end),
        .done_o    (bus_done)
    );

endmodule
